// File: rtl/tipi_4bit_bus_master.sv
// TIPI nibble-bus initiator: turns single-byte register requests into fixed
// 4-bus-clock frames, and resets the responder after every read frame.
module tipi_4bit_bus_master #(
    parameter int unsigned HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       bus_clk,
    output logic       bus_rst,
    output logic [3:0] bus_data_o,
    output logic       bus_data_oe,
    input  logic [3:0] bus_data_i
);

    localparam int unsigned HCNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HALF - 1);

    typedef enum logic [1:0] {BRST, IDLE, FRAME, DONE} state_t;

    state_t            state, state_n;
    logic [HCNT_W-1:0] hcnt, hcnt_n;
    logic [2:0]        phase, phase_n;
    logic [1:0]        sel_q, sel_n;
    logic [7:0]        wdata_q, wdata_n;
    logic [7:0]        shift_q, shift_n;

    logic              ready_d, rsp_valid_d, bus_clk_d, bus_rst_d, oe_d;
    logic [3:0]        data_d;
    logic [7:0]        rdata_d;

    logic              accept_c, half_end_c, is_write_c;

    assign accept_c   = req_valid && req_ready;
    assign half_end_c = (hcnt == HCNT_LAST);
    assign is_write_c = sel_q[1];

    // State register; every output is registered from the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BRST;
            hcnt        <= '0;
            phase       <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            shift_q     <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            bus_clk     <= 1'b0;
            bus_rst     <= 1'b1;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            phase       <= phase_n;
            sel_q       <= sel_n;
            wdata_q     <= wdata_n;
            shift_q     <= shift_n;
            req_ready   <= ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rdata_d;
            bus_clk     <= bus_clk_d;
            bus_rst     <= bus_rst_d;
            bus_data_o  <= data_d;
            bus_data_oe <= oe_d;
        end
    end

    // Next state and output values; phase is the half-period index within
    // BRST (0..1) or FRAME (0..7, odd = bus_clk high, phase[2:1] = bus cycle).
    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        phase_n     = phase;
        sel_n       = sel_q;
        wdata_n     = wdata_q;
        shift_n     = shift_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata;
        bus_clk_d   = 1'b0;
        bus_rst_d   = 1'b0;
        oe_d        = 1'b0;
        data_d      = '0;

        case (state)
            BRST: begin
                bus_rst_d = 1'b1;
                if (half_end_c) begin
                    hcnt_n = '0;
                    if (phase[0]) begin
                        state_n = IDLE;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 3'd1;
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end

            IDLE: begin
                if (accept_c) begin
                    state_n = FRAME;
                    hcnt_n  = '0;
                    phase_n = '0;
                    sel_n   = req_sel;
                    wdata_n = req_wdata;
                end else begin
                    ready_d = 1'b1;
                end
            end

            FRAME: begin
                bus_clk_d = phase[0];
                case (phase[2:1])
                    2'd0: begin
                        oe_d   = 1'b1;
                        data_d = {2'b00, sel_q};
                    end
                    2'd1: oe_d = is_write_c;
                    2'd2: begin
                        oe_d   = is_write_c;
                        data_d = is_write_c ? wdata_q[7:4] : 4'h0;
                    end
                    default: begin
                        oe_d   = is_write_c;
                        data_d = is_write_c ? wdata_q[3:0] : 4'h0;
                    end
                endcase
                // Capture in the clock that raises bus_clk for cyc2/cyc3,
                // i.e. before the responder shifts on that edge.
                if (!is_write_c && phase[2] && phase[0] && (hcnt == '0))
                    shift_n = {shift_q[3:0], bus_data_i};
                if (half_end_c) begin
                    hcnt_n  = '0;
                    phase_n = phase + 3'd1;
                    if (phase == 3'd7)
                        state_n = DONE;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end

            DONE: begin
                rsp_valid_d = 1'b1;
                if (!is_write_c)
                    rdata_d = shift_q;
                hcnt_n  = '0;
                phase_n = '0;
                state_n = is_write_c ? IDLE : BRST;
            end

            default: state_n = BRST;
        endcase
    end

endmodule

// File: tb/tb_tipi_4bit_bus_master.sv
// Bench for tipi_4bit_bus_master: three masters (HALF = 2, 1, 5), each with a
// behavioural TIPI responder, random register traffic and a response scoreboard.
`timescale 1ns/1ps
module tb_tipi_4bit_bus_master;

    typedef struct {
        bit          is_read;
        bit [1:0]    sel;
        bit [7:0]    data;
        int unsigned t_acc;
    } exp_t;

    int unsigned n_checks;
    int unsigned n_pass;
    bit          lane_done [3];
    logic        clk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int unsigned h, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL H=%0d %s: got 0x%0h, want 0x%0h", h, name, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int unsigned H = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

        logic       reset;
        logic       req_valid, req_ready;
        logic [1:0] req_sel;
        logic [7:0] req_wdata;
        logic       rsp_valid;
        logic [7:0] rsp_rdata;
        logic       bus_clk, bus_rst, bus_data_oe;
        logic [3:0] bus_data_o, bus_data_i;

        tipi_4bit_bus_master #(.HALF(H)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_sel    (req_sel),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid),
            .rsp_rdata  (rsp_rdata),
            .bus_clk    (bus_clk),
            .bus_rst    (bus_rst),
            .bus_data_o (bus_data_o),
            .bus_data_oe(bus_data_oe),
            .bus_data_i (bus_data_i)
        );

        // Responder: 2-bit edge counter, select / load / high / low nibble.
        logic [1:0] bc;
        logic       busdir;
        logic [3:0] drv, hi;
        logic [1:0] rsel;
        logic [7:0] rd_reg = 8'h00;
        logic [7:0] rc_reg = 8'h00;
        logic [7:0] td_v, tc_v;

        assign bus_data_i = bus_data_oe ? bus_data_o : (busdir ? drv : 4'h0);

        always @(posedge bus_clk or posedge bus_rst) begin
            if (bus_rst) begin
                bc     <= 2'd0;
                busdir <= 1'b0;
                drv    <= 4'h0;
            end else begin
                bc <= bc + 2'd1;
                case (bc)
                    2'd0: rsel <= bus_data_i[1:0];
                    2'd1: if (!rsel[1]) begin
                        busdir <= 1'b1;
                        drv    <= rsel[0] ? tc_v[7:4] : td_v[7:4];
                    end
                    2'd2: if (rsel[1]) hi <= bus_data_i;
                          else drv <= rsel[0] ? tc_v[3:0] : td_v[3:0];
                    default: if (rsel[1]) begin
                        if (rsel[0]) rc_reg <= {hi, bus_data_i};
                        else         rd_reg <= {hi, bus_data_i};
                    end
                endcase
            end
        end

        int unsigned cyc;
        always @(posedge clk or posedge reset)
            if (reset) cyc <= 0;
            else       cyc <= cyc + 1;

        exp_t        expq[$];
        bit          overlap;
        int unsigned ready_at;
        logic [7:0]  ref_rd, ref_rc;

        task automatic issue(input logic [1:0] sel, input logic [7:0] val, input bit hold);
            int unsigned n, t_exp, t_acc;
            exp_t e;
            t_exp     = ((cyc > ready_at) ? cyc : ready_at) + 1;
            req_sel   = sel;
            req_wdata = sel[1] ? val : 8'($urandom);
            req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 40*H + 40) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready) begin
                check(H, "accept_timeout", 0, 1);
                req_valid = 1'b0;
                return;
            end
            t_acc = cyc + 1;
            check(H, "accept_cycle", t_acc, t_exp);
            e.is_read = !sel[1];
            e.sel     = sel;
            e.data    = val;
            e.t_acc   = t_acc;
            expq.push_back(e);
            @(posedge clk);
            @(negedge clk);
            check(H, "frame_start_bitcount", 32'({busdir, bc}), 0);
            if (!sel[1]) begin
                if (sel[0]) tc_v = val;
                else        td_v = val;
            end else if (sel[0]) ref_rc = val;
            else                 ref_rd = val;
            ready_at = t_acc + 2 + 8*H + (sel[1] ? 0 : 2*H);
            if (!hold) req_valid = 1'b0;
        endtask

        // Write RD, then pull reset while the frame is in its third bus cycle.
        task automatic abort_write(input logic [7:0] val);
            int unsigned n, t_acc;
            req_sel   = 2'b10;
            req_wdata = val;
            req_valid = 1'b1;
            n = 0;
            while (!req_ready && n < 40*H + 40) begin
                @(negedge clk);
                n++;
            end
            t_acc = cyc + 1;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            while (cyc < t_acc + 2 + 4*H) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            ready_at = 2*H + 1;
            check(H, "abort_rd_kept", rd_reg, ref_rd);
        endtask

        // Driver
        initial begin
            bit prev_hold;
            int unsigned n;
            reset = 1'b1; req_valid = 1'b0; req_sel = 2'b00; req_wdata = 8'h00;
            td_v = 8'h00; tc_v = 8'h00; ref_rd = 8'h00; ref_rc = 8'h00;
            repeat (3) @(negedge clk);
            check(H, "reset_outputs",
                  32'({req_ready, rsp_valid, bus_clk, bus_rst, bus_data_oe, bus_data_o, rsp_rdata}),
                  32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00}));
            reset = 1'b0;
            for (int k = 1; k <= 2*H + 1; k++) begin
                @(negedge clk);
                check(H, "powerup_ready_rst_clk", 32'({req_ready, bus_rst, bus_clk}),
                      32'({k == 2*H + 1, k < 2*H + 1, 1'b0}));
            end
            ready_at = 2*H + 1;

            issue(2'b10, 8'hA5, 1'b0);
            issue(2'b01, 8'h3C, 1'b0);
            issue(2'b11, 8'h81, 1'b1);
            issue(2'b10, 8'h7E, 1'b0);
            issue(2'b00, 8'hF0, 1'b0);
            issue(2'b10, 8'h12, 1'b0);
            issue(2'b00, 8'h0F, 1'b0);
            abort_write(8'h99);
            issue(2'b10, 8'h55, 1'b0);

            prev_hold = 1'b0;
            for (int i = 0; i < 25; i++) begin
                bit hold;
                if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
                hold = 1'($urandom_range(0, 1));
                issue(2'($urandom), 8'($urandom), hold);
                prev_hold = hold;
            end
            req_valid = 1'b0;

            n = 0;
            while ((expq.size() != 0 || !req_ready) && n < 20*H + 40) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            check(H, "drain", 32'(expq.size()), 0);
            check(H, "final_rd", rd_reg, ref_rd);
            check(H, "final_rc", rc_reg, ref_rc);
            check(H, "bus_overlap", 32'(overlap), 0);
            lane_done[g] = 1'b1;
        end

        // Monitor: bus_clk rise times, ownership, responses and ready return.
        initial begin
            bit          prev, waiting;
            int unsigned exp_ready, brst_cnt, exp_brst;
            logic [7:0]  last_rd;
            int unsigned rises[$];
            exp_t        e;
            prev = 1'b0; waiting = 1'b0; exp_ready = 0; brst_cnt = 0; exp_brst = 0;
            last_rd = 8'h00;
            forever begin
                @(negedge clk);
                if (reset) begin
                    expq.delete();
                    rises.delete();
                    waiting = 1'b0;
                    prev    = 1'b0;
                    last_rd = 8'h00;
                end else begin
                    if (bus_clk && !prev) rises.push_back(cyc);
                    prev = bus_clk;
                    if (bus_data_oe && busdir) overlap = 1'b1;
                    if (waiting) begin
                        if (bus_rst) brst_cnt++;
                        if (req_ready) begin
                            check(H, "ready_return_cycle", cyc, exp_ready);
                            check(H, "bus_rst_len", brst_cnt, exp_brst);
                            waiting = 1'b0;
                        end else if (cyc > exp_ready + 4) begin
                            check(H, "ready_return_timeout", 0, 1);
                            waiting = 1'b0;
                        end
                    end
                    if (rsp_valid) begin
                        if (expq.size() == 0) begin
                            check(H, "unexpected_rsp", 1, 0);
                        end else begin
                            e = expq.pop_front();
                            check(H, "rsp_cycle", cyc, e.t_acc + 1 + 8*H);
                            check(H, "bclk_rise_count", 32'(rises.size()), 4);
                            for (int k = 0; k < 4; k++)
                                check(H, "bclk_rise_cycle",
                                      (k < rises.size()) ? rises[k] : 0,
                                      e.t_acc + 1 + H + 2*k*H);
                            rises.delete();
                            if (e.is_read) begin
                                check(H, "rdata", rsp_rdata, e.data);
                                last_rd = e.data;
                            end else begin
                                check(H, "rdata_held", rsp_rdata, last_rd);
                                check(H, "responder_reg", e.sel[0] ? rc_reg : rd_reg, e.data);
                            end
                            waiting   = 1'b1;
                            brst_cnt  = 0;
                            exp_brst  = e.is_read ? 2*H : 0;
                            exp_ready = e.t_acc + 2 + 8*H + exp_brst;
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = lane_done[0] && lane_done[1] && lane_done[2];
        end
        if (!all_done)
            check(0, "lane_timeout", 32'({lane_done[2], lane_done[1], lane_done[0]}), 32'h7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
